// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
//   Instruction fetch stage of the 5-bit CPU, directly upstream of the CU.
//   Holds the PC, fetches INSTR_W-bit instruction words over a req/ack
//   handshake, latches them in the IR, and presents opcode/immediate to the
//   CU and datapath. The CU's jump decision selects the next PC.
//
//   Build option: IFETCH_HALT_EN
//     defined   - opcode all-ones in EXEC (stall=0) enters HALT after the
//                 normal PC update; only rst_n leaves HALT.
//     undefined - all-ones opcode is an ordinary instruction, halted=0.
//
// Ports
//   clk, rst_n        clock (rising edge), async active-low reset
//   imem_req/addr     fetch request (held until ack) and address (= pc)
//   imem_ack/rdata    memory response; rdata sampled on req & ack
//   stall             downstream not ready, freezes EXEC
//   jmp_sel           CU jump-taken decision for the current IR
//   opcode, imm       IR fields; imm doubles as the jump target
//   instr_valid       opcode/imm carry a live instruction
//   pc                address of the next fetch
//   halted            core halted
// ---------------------------------------------------------------------------
module ifetch_unit #(
    parameter int PC_W    = 5,
    parameter int OPC_W   = 4,
    parameter int IMM_W   = 5,
    parameter int INSTR_W = 9   // must equal OPC_W + IMM_W
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               jmp_sel,
    output logic [OPC_W-1:0]   opcode,
    output logic [IMM_W-1:0]   imm,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc,
    output logic               halted
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    state_t               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic                 req_q, valid_q;
    logic                 halt_op;

    assign opcode      = ir_q[INSTR_W-1 -: OPC_W];
    assign imm         = ir_q[IMM_W-1:0];
    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign imem_req    = req_q;
    assign instr_valid = valid_q;

`ifdef IFETCH_HALT_EN
    assign halt_op = (opcode == {OPC_W{1'b1}});
`else
    assign halt_op = 1'b0;
`endif

    // Next-state / next-datapath logic. Outputs are registered from the
    // next state so that req/valid/halted line up with the state they
    // describe without any combinational decode on the ports.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_q + PC_W'(1);   // wraps naturally
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Under stall the jump decision is ignored entirely; it only
                // counts in the cycle the instruction actually retires.
                if (!stall) begin
                    if (jmp_sel)
                        pc_d = PC_W'(imm);
                    state_d = halt_op ? S_HALT : S_FETCH;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            req_q   <= (state_d == S_FETCH);
            valid_q <= (state_d == S_EXEC);
        end
    end

`ifdef IFETCH_HALT_EN
    logic halted_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) halted_q <= 1'b0;
        else        halted_q <= (state_d == S_HALT);
    end
    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

endmodule
